bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader.sv | 248 ++++++++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Polls a control word at BRAM word 0. When GO is set, the reader streams the
// payload words 1..N onto a valid/ready interface and then writes an
// acknowledge word back to word 0 with DONE set (ERR set if N was out of range).
// Optional feature: define BRAM_STREAM_READER_CHECKSUM_EN to write a 32-bit
// wrapping sum of the streamed words to word N+1 before the acknowledge.
module bram_stream_reader #(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter int unsigned POLL_INTERVAL = 256
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] BRAM_addr,
  output logic        BRAM_clk,
  output logic [31:0] BRAM_din,
  input  logic [31:0] BRAM_dout,
  output logic        BRAM_en,
  output logic        BRAM_rst,
  output logic [3:0]  BRAM_we,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic        done
);

`ifdef BRAM_STREAM_READER_CHECKSUM_EN
  // One word past the payload is reserved for the checksum.
  localparam int unsigned MaxN = DEPTH_WORDS - 2;
`else
  localparam int unsigned MaxN = DEPTH_WORDS - 1;
`endif

  localparam int unsigned CntW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPollRd,
    StPollChk,
    StRd,
    StRdWait,
    StHold,
    StAck
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
    ,
    StCsum
`endif
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_poll_cnt;
  logic [15:0]     r_n;
  logic [15:0]     r_idx;
  logic            r_err;
  logic [31:0]     r_bram_addr;
  logic [31:0]     r_bram_din;
  logic            r_bram_en;
  logic [3:0]      r_bram_we;
  logic [31:0]     r_m_data;
  logic            r_m_valid;
  logic            r_busy;
  logic            r_done;
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
  logic [31:0]     r_sum;
`endif

  logic            w_go;
  logic [15:0]     w_dout_n;
  logic            w_n_ok;
  logic [15:0]     w_idx_inc;
  logic [31:0]     w_next_rd_addr;
  logic [31:0]     w_ack_err_word;
  logic [31:0]     w_ack_word;
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
  logic [31:0]     w_sum_next;
  logic [16:0]     w_n_inc;
  logic [31:0]     w_csum_addr;
`endif

  // Decode the control word and precompute addresses and acknowledge words.
  always_comb begin
    w_go           = BRAM_dout[31];
    w_dout_n       = BRAM_dout[15:0];
    w_n_ok         = (w_dout_n != 16'd0) && (32'(w_dout_n) <= MaxN);
    w_idx_inc      = r_idx + 16'd1;
    w_next_rd_addr = {14'b0, w_idx_inc, 2'b00};
    // ERR path takes N straight from the bus since r_n is latched on the same edge.
    w_ack_err_word = {2'b01, 1'b1, 13'b0, w_dout_n};
    w_ack_word     = {2'b01, r_err, 13'b0, r_n};
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
    w_sum_next     = r_sum + r_m_data;
    w_n_inc        = {1'b0, r_n} + 17'd1;
    w_csum_addr    = {13'b0, w_n_inc, 2'b00};
`endif
  end

  // Control FSM; every BRAM and stream output is registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_poll_cnt  <= '0;
      r_n         <= 16'd0;
      r_idx       <= 16'd0;
      r_err       <= 1'b0;
      r_bram_addr <= 32'd0;
      r_bram_din  <= 32'd0;
      r_bram_en   <= 1'b0;
      r_bram_we   <= 4'h0;
      r_m_data    <= 32'd0;
      r_m_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
      r_sum       <= 32'd0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (r_poll_cnt == LastCnt) begin
            r_poll_cnt  <= '0;
            r_bram_en   <= 1'b1;
            r_bram_we   <= 4'h0;
            r_bram_addr <= 32'd0;
            r_state     <= StPollRd;
          end else begin
            r_poll_cnt <= r_poll_cnt + 1'b1;
          end
        end

        StPollRd: begin
          r_bram_en <= 1'b0;
          r_state   <= StPollChk;
        end

        StPollChk: begin
          r_n <= w_dout_n;
          if (!w_go) begin
            r_poll_cnt <= '0;
            r_state    <= StIdle;
          end else if (w_n_ok) begin
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            r_idx       <= 16'd1;
            r_bram_en   <= 1'b1;
            r_bram_addr <= 32'd4;
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
            r_sum       <= 32'd0;
`endif
            r_state     <= StRd;
          end else begin
            // Bad length: skip streaming and acknowledge with ERR.
            r_busy      <= 1'b1;
            r_err       <= 1'b1;
            r_bram_en   <= 1'b1;
            r_bram_we   <= 4'hF;
            r_bram_addr <= 32'd0;
            r_bram_din  <= w_ack_err_word;
            r_done      <= 1'b1;
            r_state     <= StAck;
          end
        end

        StRd: begin
          r_bram_en <= 1'b0;
          r_state   <= StRdWait;
        end

        StRdWait: begin
          r_m_data  <= BRAM_dout;
          r_m_valid <= 1'b1;
          r_state   <= StHold;
        end

        StHold: begin
          if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
            r_sum     <= w_sum_next;
`endif
            if (r_idx < r_n) begin
              r_idx       <= w_idx_inc;
              r_bram_en   <= 1'b1;
              r_bram_addr <= w_next_rd_addr;
              r_state     <= StRd;
            end else begin
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
              r_bram_en   <= 1'b1;
              r_bram_we   <= 4'hF;
              r_bram_addr <= w_csum_addr;
              r_bram_din  <= w_sum_next;
              r_state     <= StCsum;
`else
              r_bram_en   <= 1'b1;
              r_bram_we   <= 4'hF;
              r_bram_addr <= 32'd0;
              r_bram_din  <= w_ack_word;
              r_done      <= 1'b1;
              r_state     <= StAck;
`endif
            end
          end
        end

`ifdef BRAM_STREAM_READER_CHECKSUM_EN
        StCsum: begin
          r_bram_en   <= 1'b1;
          r_bram_we   <= 4'hF;
          r_bram_addr <= 32'd0;
          r_bram_din  <= w_ack_word;
          r_done      <= 1'b1;
          r_state     <= StAck;
        end
`endif

        StAck: begin
          r_bram_en   <= 1'b0;
          r_bram_we   <= 4'h0;
          r_bram_addr <= 32'd0;
          r_bram_din  <= 32'd0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_poll_cnt  <= '0;
          r_state     <= StIdle;
        end

        default: begin
          r_bram_en  <= 1'b0;
          r_bram_we  <= 4'h0;
          r_poll_cnt <= '0;
          r_state    <= StIdle;
        end
      endcase
    end
  end

  assign BRAM_clk  = clk;
  assign BRAM_rst  = ~rstn;
  assign BRAM_addr = r_bram_addr;
  assign BRAM_din  = r_bram_din;
  assign BRAM_en   = r_bram_en;
  assign BRAM_we   = r_bram_we;
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a small synchronous BRAM model.
module tb_bram_stream_reader;
  localparam int unsigned Depth = 16;
  localparam int unsigned Poll  = 8;
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
  localparam int ExpWr = 2;
`else
  localparam int ExpWr = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] BRAM_addr;
  logic        BRAM_clk;
  logic [31:0] BRAM_din;
  logic [31:0] bram_dout = 32'd0;
  logic        BRAM_en;
  logic        BRAM_rst;
  logic [3:0]  BRAM_we;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  bram_stream_reader #(
    .DEPTH_WORDS  (Depth),
    .POLL_INTERVAL(Poll)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .BRAM_addr(BRAM_addr),
    .BRAM_clk (BRAM_clk),
    .BRAM_din (BRAM_din),
    .BRAM_dout(bram_dout),
    .BRAM_en  (BRAM_en),
    .BRAM_rst (BRAM_rst),
    .BRAM_we  (BRAM_we),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done)
  );

  // BRAM model: read-first, one-cycle read latency; bench preload port has its own strobe.
  logic [31:0] mem [0:Depth-1];
  logic        tb_wr_en = 1'b0;
  logic [3:0]  tb_wr_idx = 4'd0;
  logic [31:0] tb_wr_data = 32'd0;
  always @(posedge clk) begin
    if (tb_wr_en) mem[tb_wr_idx] <= tb_wr_data;
    if (BRAM_en) begin
      if (BRAM_we == 4'hF) mem[BRAM_addr[5:2]] <= BRAM_din;
      bram_dout <= mem[BRAM_addr[5:2]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: observes outputs on the falling edge.
  logic [31:0] got_q[$];
  int          poll_q[$];
  logic [31:0] wr_q[$];
  int          done_cnt = 0;
  int          valid_cyc = 0;
  int          busy_cyc = 0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;
  always @(negedge clk) begin
    if (m_valid && m_ready) got_q.push_back(m_data);
    if (rstn && prev_stall && (!m_valid || m_data != prev_data)) stab_err <= stab_err + 1;
    prev_stall <= rstn && m_valid && !m_ready;
    prev_data  <= m_data;
    if (done) done_cnt <= done_cnt + 1;
    if (m_valid) valid_cyc <= valid_cyc + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (BRAM_en && BRAM_we == 4'h0 && BRAM_addr == 32'd0) poll_q.push_back(cyc);
    if (BRAM_en && BRAM_we != 4'h0) wr_q.push_back(BRAM_addr);
  end

  // Ready driver: 0 = always ready, 1 = ready one cycle in four, 2 = stall on word 0x22.
  int rdy_mode = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 4 == 0);
        default: m_ready = !(m_valid && m_data == 32'h22);
      endcase
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic mem_wr(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    tb_wr_idx  = idx;
    tb_wr_data = data;
    tb_wr_en   = 1'b1;
    @(negedge clk);
    tb_wr_en   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(done_cnt != start), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int got_b, wr_b, done_b, valid_b, busy_b, poll_b, k;

  initial begin
    // Reset values.
    #3 rstn = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_bram_ctl", {27'd0, BRAM_en, BRAM_we}, 32'd0);
    check("rst_bram_addr", BRAM_addr, 32'd0);
    check("rst_bram_din", BRAM_din, 32'd0);
    check("rst_bram_rst", 32'(BRAM_rst), 32'd1);
    for (int i = 0; i < int'(Depth); i++) mem_wr(4'(i), 32'd0);

    // Basic transfer, always ready.
    mem_wr(4'd1, 32'h11);
    mem_wr(4'd2, 32'h22);
    mem_wr(4'd3, 32'h33);
    mem_wr(4'd0, 32'h8000_0003);
    got_b = got_q.size(); wr_b = wr_q.size(); done_b = done_cnt;
    @(negedge clk);
    rstn = 1'b1;
    wait_done("t1_done", 300);
    repeat (20) @(negedge clk);
    check("t1_count", 32'(got_q.size() - got_b), 32'd3);
    check("t1_w1", got_q[got_b], 32'h11);
    check("t1_w2", got_q[got_b+1], 32'h22);
    check("t1_w3", got_q[got_b+2], 32'h33);
    check("t1_ctrl", mem[0], 32'h4000_0003);
    check("t1_done_pulses", 32'(done_cnt - done_b), 32'd1);
    check("t1_writes", 32'(wr_q.size() - wr_b), 32'(ExpWr));
    check("t1_ack_addr", wr_q[wr_b+ExpWr-1], 32'd0);

    // Same payload, ready one cycle in four.
    rdy_mode = 1;
    got_b = got_q.size(); done_b = done_cnt;
    mem_wr(4'd0, 32'h8000_0003);
    wait_done("t2_done", 400);
    repeat (20) @(negedge clk);
    check("t2_count", 32'(got_q.size() - got_b), 32'd3);
    check("t2_w1", got_q[got_b], 32'h11);
    check("t2_w2", got_q[got_b+1], 32'h22);
    check("t2_w3", got_q[got_b+2], 32'h33);
    check("t2_stable", 32'(stab_err), 32'd0);
    check("t2_ctrl", mem[0], 32'h4000_0003);
    check("t2_done_pulses", 32'(done_cnt - done_b), 32'd1);
    rdy_mode = 0;

    // N = 0 is an error: no data, ERR acknowledge.
    valid_b = valid_cyc;
    mem_wr(4'd0, 32'h8000_0000);
    wait_done("t3_done", 300);
    check("t3_no_valid", 32'(valid_cyc - valid_b), 32'd0);
    check("t3_ctrl", mem[0], 32'h6000_0000);

    // N = 16 exceeds the BRAM.
    valid_b = valid_cyc;
    mem_wr(4'd0, 32'h8000_0010);
    wait_done("t3b_done", 300);
    check("t3b_no_valid", 32'(valid_cyc - valid_b), 32'd0);
    check("t3b_ctrl", mem[0], 32'h6000_0010);

    // Largest payload for the build.
    for (int i = 1; i < int'(Depth); i++) mem_wr(4'(i), 32'(i * 3));
    got_b = got_q.size();
    mem_wr(4'd0, 32'h8000_000F);
    wait_done("t3c_done", 400);
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
    check("t3c_count", 32'(got_q.size() - got_b), 32'd0);
    check("t3c_ctrl", mem[0], 32'h6000_000F);
`else
    check("t3c_count", 32'(got_q.size() - got_b), 32'd15);
    check("t3c_first", got_q[got_b], 32'h3);
    check("t3c_last", got_q[got_b+14], 32'h2D);
    check("t3c_ctrl", mem[0], 32'h4000_000F);
`endif

    // GO clear: polling only, period Poll+2, no writes, never busy.
    mem_wr(4'd0, 32'h0000_0005);
    repeat (12) @(negedge clk);
    poll_b = poll_q.size(); wr_b = wr_q.size(); busy_b = busy_cyc;
    repeat (45) @(negedge clk);
    check("t4_polls", 32'(poll_q.size() - poll_b >= 4), 32'd1);
    check("t4_period_a", 32'(poll_q[poll_b+1] - poll_q[poll_b]), 32'(Poll + 2));
    check("t4_period_b", 32'(poll_q[poll_b+2] - poll_q[poll_b+1]), 32'(Poll + 2));
    check("t4_no_writes", 32'(wr_q.size() - wr_b), 32'd0);
    check("t4_not_busy", 32'(busy_cyc - busy_b), 32'd0);
    check("t4_ctrl", mem[0], 32'h0000_0005);

    // Reset while holding word 2 of 3.
    mem_wr(4'd1, 32'h11);
    mem_wr(4'd2, 32'h22);
    mem_wr(4'd3, 32'h33);
    rdy_mode = 2;
    done_b = done_cnt; wr_b = wr_q.size();
    mem_wr(4'd0, 32'h8000_0003);
    k = 0;
    while (!(m_valid && m_data == 32'h22 && !m_ready) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("t5_reached_hold", 32'(k < 300), 32'd1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t5_rst_valid", 32'(m_valid), 32'd0);
    check("t5_rst_data", m_data, 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_en", 32'(BRAM_en), 32'd0);
    check("t5_rst_addr", BRAM_addr, 32'd0);
    check("t5_go_kept", mem[0], 32'h8000_0003);
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    got_b = got_q.size();
    rstn = 1'b1;
    wait_done("t5_done", 300);
    repeat (5) @(negedge clk);
    check("t5_count", 32'(got_q.size() - got_b), 32'd3);
    check("t5_w1", got_q[got_b], 32'h11);
    check("t5_w2", got_q[got_b+1], 32'h22);
    check("t5_w3", got_q[got_b+2], 32'h33);
    check("t5_ctrl", mem[0], 32'h4000_0003);
    check("t5_done_pulses", 32'(done_cnt - done_b), 32'd1);
    check("t5_writes", 32'(wr_q.size() - wr_b), 32'(ExpWr));

`ifdef BRAM_STREAM_READER_CHECKSUM_EN
    // Wrapping checksum lands at word N+1 before the acknowledge.
    mem_wr(4'd1, 32'hFFFF_FFFF);
    mem_wr(4'd2, 32'h0000_0002);
    mem_wr(4'd3, 32'h0000_0000);
    wr_b = wr_q.size();
    mem_wr(4'd0, 32'h8000_0002);
    wait_done("t6_done", 300);
    check("t6_writes", 32'(wr_q.size() - wr_b), 32'd2);
    check("t6_csum_addr", wr_q[wr_b], 32'd12);
    check("t6_ack_addr", wr_q[wr_b+1], 32'd0);
    check("t6_csum", mem[3], 32'h0000_0001);
    check("t6_ctrl", mem[0], 32'h4000_0002);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
